mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU's MMIO port, directly downstream of the top-level core/crossbar MMIO outputs. Software writes bytes into a TX FIFO. A baud-rate FSM serialises them as 8N1 frames on o_tx. Status, divisor and control registers are readable through the combinational MMIO read path.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
DEFAULT_DIV, 16'd433, reset value of DIVISOR; clocks per bit = DIV+1.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
i_addr  input  30  MMIO word address; only [1:0] decoded, upper bits ignored
i_data  input  32  MMIO write data
i_mask  input  4  byte enables for writes
i_wren  input  1  write strobe, single cycle
o_data  output  32  MMIO read data, combinational from i_addr
o_tx  output  1  serial line, idle high

Behaviour:
- Reset (rst_n low at a clk edge), applied to every state bit:
  - o_tx=1, FSM=IDLE, FIFO empty, overflow=0.
  - DIVISOR=DEFAULT_DIV, CTRL.enable=1.
- Register map (i_addr[1:0]). Writes commit at the clk edge with i_wren=1.
  - 0 TXDATA: write with i_mask[0]=1 pushes i_data[7:0]; mask[0]=0 means no push; reads return 0.
  - 1 STATUS: read {27'b0, overflow[4], busy[3], full[2], empty[1], enable[0]}. Writing 1 to bit 4 with mask[0] clears overflow; other bits are read-only.
  - 2 DIVISOR: R/W, 16 bits in [15:0], byte-masked by mask[1:0]; reads zero-extended.
  - 3 CTRL: bit0 enable (R/W). bit1 flush: write-1 empties the FIFO at that edge; reads as 0.
- Reads are purely combinational with no side effects. Undecoded bits read 0.
- FIFO:
  - Push when full is dropped and sets overflow (sticky).
  - Push and pop on the same edge both succeed, including when full; count is unchanged.
  - Flush and push on the same edge: flush wins, FIFO ends empty.
  - Pointers wrap modulo FIFO_DEPTH; a count register of width log2(DEPTH)+1 distinguishes full from empty.
- FSM states and transitions: IDLE -> START -> DATA -> STOP -> (START | IDLE).
  - IDLE: if enable and !empty, pop the head into the shift register, latch DIVISOR into the bit-period register, go to START. o_tx=1.
  - START: o_tx=0 for DIV+1 cycles.
  - DATA: 8 bits LSB first, each held DIV+1 cycles. A 3-bit counter selects the bit.
  - STOP: o_tx=1 for DIV+1 cycles. At the end, if enable and !empty, pop and go straight to START (no idle gap); else go to IDLE.
- Bit timing: a 16-bit down-counter loaded with the latched DIV. The bit ends when the counter is 0.
- Latency and frame length:
  - Byte pushed at edge N into an empty FIFO while IDLE: FSM pops at edge N+1; o_tx falls after edge N+1.
  - Frame length is exactly 10*(DIV+1) cycles.
- Mid-frame DIVISOR writes affect only the next frame. DIV=0 gives 1 cycle per bit.
- Clearing enable mid-frame: the current frame completes, and no new frame starts until enable is set again.
- busy = (FSM != IDLE).
- Reset mid-frame: o_tx returns to 1 at that edge and the frame is abandoned.
- Output registering: o_tx is registered; no glitches.

Decomposition:
- Package uart_pkg:
  - Register offsets: UART_REG_TXDATA=0, STATUS=1, DIVISOR=2, CTRL=3.
  - STATUS/CTRL bit positions.
  - FSM state enum (IDLE, START, DATA, STOP).
  - Frame constants: 8 data bits, 1 stop bit.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - push/pop/flush inputs; data, full and empty outputs.
  - Same-cycle rules as above.
- Top level holds register decode, read mux and the TX FSM.

Test Plan:
- Reset, then read STATUS and DIVISOR -> STATUS=0x03 (empty, enable), DIVISOR=433, o_tx=1.
- Write DIVISOR=3, TXDATA=0x55 -> o_tx low 4 cycles from edge N+1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Total 40 cycles; busy=1 throughout.
- DIV=0; write 0xA5 and 0x3C back-to-back -> 20 contiguous bit-cycles with no idle gap between the stop bit and the second start bit; empty=1 after the second pop.
- DIV=0xFFFF, enable=1; push 17 bytes quickly -> first byte popped into the FSM. The remaining 16 fill the FIFO (full=1). One extra write sets overflow=1. Writing 0x10 to STATUS clears it.
- Fill FIFO with 5 bytes, write CTRL=0x3 mid-frame -> current frame completes unchanged; FIFO empty; o_tx stays idle after the stop bit.
- Clear enable mid-frame with 2 bytes queued -> frame finishes, FSM idles, FIFO holds 2. Set enable -> transmission resumes. Also pulse rst_n mid-frame -> o_tx=1 after that edge, FIFO empty.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// uart_pkg: register map, status/control bit positions, frame constants and TX FSM states
package uart_pkg;
  localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;
  localparam logic [1:0] UART_REG_CTRL    = 2'd3;
  localparam int ST_ENABLE   = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_BUSY     = 3;
  localparam int ST_OVERFLOW = 4;
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU MMIO port as seen by the UART (word address, masked write, combinational read)
interface mmio_uart_tx_if;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        wren;
  logic [31:0] rdata;
  modport master (output addr, wdata, mask, wren, input rdata);
  modport slave (input addr, wdata, mask, wren, output rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO; flush beats push, push+pop on the same edge both succeed even when full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '{default: '0};
    else if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO-mapped 8N1 UART transmitter with TX FIFO, divisor and control registers
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  mmio,
  output logic           o_tx
);
  logic [1:0] a;
  logic wr_tx, wr_st, wr_div, wr_ctl;
  logic push, pop, flush, full, empty, busy;
  logic [7:0] head;
  logic [15:0] div_q, div_d;
  logic en_q, en_d, ovf_q, ovf_d;
  logic [4:0] status;
  tx_state_e state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_q;
  logic [15:0] cnt_q, per_q;
  logic tx_q, bit_end, load;
  logic unused_bits;
  assign a      = mmio.addr[1:0];
  assign wr_tx  = mmio.wren & (a == UART_REG_TXDATA);
  assign wr_st  = mmio.wren & (a == UART_REG_STATUS);
  assign wr_div = mmio.wren & (a == UART_REG_DIVISOR);
  assign wr_ctl = mmio.wren & (a == UART_REG_CTRL);
  assign push   = wr_tx & mmio.mask[0];
  assign flush  = wr_ctl & mmio.mask[0] & mmio.wdata[CTRL_FLUSH];
  assign busy   = state_q != IDLE;
  assign bit_end = cnt_q == '0;
  assign load   = en_q & !empty & (state_q == IDLE || (state_q == STOP && bit_end));
  assign pop    = load;
  assign o_tx   = tx_q;
  assign unused_bits = ^{mmio.addr[29:2], mmio.wdata[31:16], mmio.mask[3:2]};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .flush_i(flush),
    .data_i(mmio.wdata[7:0]), .data_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    div_d = {wr_div & mmio.mask[1] ? mmio.wdata[15:8] : div_q[15:8],
             wr_div & mmio.mask[0] ? mmio.wdata[7:0] : div_q[7:0]};
    en_d  = wr_ctl & mmio.mask[0] ? mmio.wdata[CTRL_ENABLE] : en_q;
    ovf_d = (ovf_q & !(wr_st & mmio.mask[0] & mmio.wdata[ST_OVERFLOW])) | (push & full & !pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= DEFAULT_DIV;
      en_q  <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      en_q  <= en_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    status = '0;
    status[ST_ENABLE]   = en_q;
    status[ST_EMPTY]    = empty;
    status[ST_FULL]     = full;
    status[ST_BUSY]     = busy;
    status[ST_OVERFLOW] = ovf_q;
    mmio.rdata = a == UART_REG_STATUS  ? {27'b0, status} :
                 a == UART_REG_DIVISOR ? {16'b0, div_q} :
                 a == UART_REG_CTRL    ? {31'b0, en_q} : '0;
  end
  // load covers both the IDLE start and the back-to-back STOP->START hand-off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      tx_q    <= 1'b1;
    end else if (load) begin
      state_q <= START;
      shift_q <= head;
      per_q   <= div_q;
      cnt_q   <= div_q;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: tx_q <= 1'b1;
        START:
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            cnt_q   <= per_q;
            tx_q    <= shift_q[0];
          end else cnt_q <= cnt_q - 16'd1;
        DATA:
          if (bit_end) begin
            cnt_q <= per_q;
            bit_q <= bit_q + 3'd1;
            state_q <= bit_q == 3'(DATA_BITS - 1) ? STOP : DATA;
            tx_q  <= bit_q == 3'(DATA_BITS - 1) ? 1'b1 : shift_q[bit_q + 3'd1];
          end else cnt_q <= cnt_q - 16'd1;
        STOP:
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end else cnt_q <= cnt_q - 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register-map vector table plus directed serial-frame sequences for mmio_uart_tx
module tb_mmio_uart_tx;
  import uart_pkg::*;
  typedef struct {
    logic        wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [29:0] ra;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_tx;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0, t1;
  logic [31:0] rdv;
  logic hist_tx [4096];
  logic [4:0] hist_st [4096];
  vec_t tv [16];
  mmio_uart_tx_if bus ();
  mmio_uart_tx dut (.clk(clk), .rst_n(rst_n), .mmio(bus), .o_tx(o_tx));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    hist_tx[cyc % 4096] <= o_tx;
    hist_st[cyc % 4096] <= bus.rdata[4:0];
    cyc <= cyc + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.addr = {28'b0, a};
    bus.wdata = d;
    bus.mask = m;
    bus.wren = 1'b1;
    @(posedge clk);
    #1 bus.wren = 1'b0;
  endtask
  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    bus.addr = a;
    #1 d = bus.rdata;
  endtask
  task automatic rd_chk(input string nm, input logic [29:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_frame(input string nm, input int base, input logic [7:0] b, input int cpb);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * cpb; k++)
      chk($sformatf("%s tx[%0d]", nm, k), 32'(hist_tx[(base + k) % 4096]), 32'(f[k / cpb]));
  endtask
  task automatic chk_idle(input string nm, input int base, input int n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s idle[%0d]", nm, k), 32'(hist_tx[(base + k) % 4096]), 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{1'b0, 2'd0, 32'h0, 4'h0, 30'd1, 32'h3};
    tv[1]  = '{1'b0, 2'd0, 32'h0, 4'h0, 30'd2, 32'd433};
    tv[2]  = '{1'b0, 2'd0, 32'h0, 4'h0, 30'd0, 32'h0};
    tv[3]  = '{1'b0, 2'd0, 32'h0, 4'h0, 30'd3, 32'h1};
    tv[4]  = '{1'b0, 2'd0, 32'h0, 4'h0, 30'h3FFF_FFFE, 32'd433};
    tv[5]  = '{1'b1, 2'd2, 32'h0000_1234, 4'b0001, 30'd2, 32'h0134};
    tv[6]  = '{1'b1, 2'd2, 32'h0000_AB00, 4'b0010, 30'd2, 32'hAB34};
    tv[7]  = '{1'b1, 2'd2, 32'hFFFF_0003, 4'b1100, 30'd2, 32'hAB34};
    tv[8]  = '{1'b1, 2'd3, 32'h0, 4'b0001, 30'd3, 32'h0};
    tv[9]  = '{1'b1, 2'd1, 32'hFFFF_FFEF, 4'hF, 30'd1, 32'h2};
    tv[10] = '{1'b1, 2'd0, 32'h77, 4'b1110, 30'd1, 32'h2};
    tv[11] = '{1'b1, 2'd0, 32'h77, 4'b0001, 30'd1, 32'h0};
    tv[12] = '{1'b1, 2'd0, 32'h12, 4'b0001, 30'd0, 32'h0};
    tv[13] = '{1'b1, 2'd3, 32'h2, 4'b0001, 30'd1, 32'h2};
    tv[14] = '{1'b1, 2'd3, 32'h3, 4'b0001, 30'd3, 32'h1};
    tv[15] = '{1'b0, 2'd0, 32'h0, 4'h0, 30'd1, 32'h3};
    bus.addr = '0;
    bus.wdata = '0;
    bus.mask = '0;
    bus.wren = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cycles(1);
    chk("reset o_tx", 32'(o_tx), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (tv[i].wr) wr(tv[i].wa, tv[i].wd, tv[i].wm);
      rd(tv[i].ra, rdv);
      chk($sformatf("vec%0d", i), rdv, tv[i].exp);
    end
    // single 0x55 frame at 4 clocks per bit
    wr(UART_REG_DIVISOR, 32'd3, 4'b0011);
    wr(UART_REG_TXDATA, 32'h55, 4'b0001);
    t0 = cyc;
    bus.addr = 30'd1;
    cycles(45);
    chk("s1 pre", 32'(hist_tx[t0 % 4096]), 32'd1);
    chk_frame("s1", t0 + 1, 8'h55, 4);
    for (int k = 0; k < 40; k++)
      chk($sformatf("s1 busy[%0d]", k), 32'(hist_st[(t0 + 1 + k) % 4096][ST_BUSY]), 32'd1);
    chk("s1 post tx", 32'(hist_tx[(t0 + 41) % 4096]), 32'd1);
    chk("s1 post busy", 32'(hist_st[(t0 + 41) % 4096][ST_BUSY]), 32'd0);
    // back-to-back frames at one clock per bit
    wr(UART_REG_DIVISOR, 32'd0, 4'b0011);
    wr(UART_REG_TXDATA, 32'hA5, 4'b0001);
    t0 = cyc;
    wr(UART_REG_TXDATA, 32'h3C, 4'b0001);
    bus.addr = 30'd1;
    cycles(25);
    chk_frame("s2a", t0 + 1, 8'hA5, 1);
    chk_frame("s2b", t0 + 11, 8'h3C, 1);
    chk("s2 empty before 2nd pop", 32'(hist_st[(t0 + 10) % 4096][ST_EMPTY]), 32'd0);
    chk("s2 empty after 2nd pop", 32'(hist_st[(t0 + 11) % 4096][ST_EMPTY]), 32'd1);
    chk("s2 post tx", 32'(hist_tx[(t0 + 21) % 4096]), 32'd1);
    chk("s2 post busy", 32'(hist_st[(t0 + 21) % 4096][ST_BUSY]), 32'd0);
    // flush mid-frame
    wr(UART_REG_DIVISOR, 32'd1, 4'b0011);
    wr(UART_REG_TXDATA, 32'h11, 4'b0001);
    t0 = cyc;
    wr(UART_REG_TXDATA, 32'h22, 4'b0001);
    wr(UART_REG_TXDATA, 32'h33, 4'b0001);
    wr(UART_REG_TXDATA, 32'h44, 4'b0001);
    wr(UART_REG_TXDATA, 32'h55, 4'b0001);
    wr(UART_REG_CTRL, 32'h3, 4'b0001);
    bus.addr = 30'd1;
    cycles(42);
    chk("s4 flushed empty", 32'(hist_st[(t0 + 5) % 4096][ST_EMPTY]), 32'd1);
    chk("s4 flushed busy", 32'(hist_st[(t0 + 5) % 4096][ST_BUSY]), 32'd1);
    chk_frame("s4", t0 + 1, 8'h11, 2);
    chk_idle("s4", t0 + 21, 20);
    rd_chk("s4 status", 30'd1, 32'h3);
    // disable mid-frame, then resume
    wr(UART_REG_TXDATA, 32'hC1, 4'b0001);
    t0 = cyc;
    wr(UART_REG_TXDATA, 32'hC2, 4'b0001);
    wr(UART_REG_TXDATA, 32'hC3, 4'b0001);
    wr(UART_REG_CTRL, 32'h0, 4'b0001);
    cycles(25);
    chk_frame("s5a", t0 + 1, 8'hC1, 2);
    chk_idle("s5 paused", t0 + 21, 6);
    rd_chk("s5 paused status", 30'd1, 32'h0);
    wr(UART_REG_CTRL, 32'h1, 4'b0001);
    t1 = cyc;
    bus.addr = 30'd1;
    cycles(45);
    chk("s5 resume pre", 32'(hist_tx[t1 % 4096]), 32'd1);
    chk_frame("s5b", t1 + 1, 8'hC2, 2);
    chk_frame("s5c", t1 + 21, 8'hC3, 2);
    chk("s5 post tx", 32'(hist_tx[(t1 + 41) % 4096]), 32'd1);
    rd_chk("s5 post status", 30'd1, 32'h3);
    // fill, overflow, clear, then reset mid-frame
    wr(UART_REG_DIVISOR, 32'hFFFF, 4'b0011);
    for (int i = 0; i < 17; i++) wr(UART_REG_TXDATA, 32'(i), 4'b0001);
    rd_chk("s3 full", 30'd1, 32'h0D);
    wr(UART_REG_TXDATA, 32'hEE, 4'b0001);
    rd_chk("s3 overflow", 30'd1, 32'h1D);
    chk("s3 start bit", 32'(o_tx), 32'd0);
    wr(UART_REG_STATUS, 32'h10, 4'b0001);
    rd_chk("s3 ovf cleared", 30'd1, 32'h0D);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst mid-frame o_tx", 32'(o_tx), 32'd1);
    rd_chk("rst mid-frame status", 30'd1, 32'h3);
    rd_chk("rst mid-frame div", 30'd2, 32'd433);
    @(negedge clk) rst_n = 1'b1;
    cycles(3);
    chk("rst after o_tx", 32'(o_tx), 32'd1);
    rd_chk("rst after status", 30'd1, 32'h3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
